// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyphs, blank pattern,
// and anode-off value. All segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;  // lower-case b
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;  // lower-case d
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Write port into the display shadow registers: one-cycle strobe plus the
// value, decimal-point mask and digit-enable mask it carries.
interface seg7_scan_driver_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic [7:0]  wr_mask;

  modport master (output wr_en, wr_data, wr_dp, wr_mask);
  modport slave  (input  wr_en, wr_data, wr_dp, wr_mask);
endinterface

// File: rtl/seg7_hex_lut.sv
// Nibble to active-low seven-segment glyph, purely combinational.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode driver with double-buffered value,
// decimal-point and enable masks; new writes take effect only at frame wrap.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  wr,
  input  logic               lzb,
  output logic [7:0]         AN,
  output logic [6:0]         HEX,
  output logic               DP,
  output logic               frame_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          pending_q, pending_d;
  logic [31:0]   sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [7:0]    sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [7:0]    sh_mask_q, sh_mask_d, act_mask_q, act_mask_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    hex_q, hex_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic       tick, wrap, upper_zero, blank;
  logic [3:0] nibble;
  logic [6:0] seg;

  assign tick = (div_cnt_q == DW'(CLK_DIV - 1));
  assign wrap = tick && (idx_q == 3'(NUM_DIGITS - 1));

  // Scan counters and double buffer. The wrap copies the shadow as it was
  // before any same-cycle write, so that write stays pending for next frame.
  always_comb begin
    div_cnt_d  = tick ? '0 : div_cnt_q + DW'(1);
    idx_d      = idx_q;
    if (tick) idx_d = wrap ? 3'd0 : idx_q + 3'd1;

    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_mask_d = act_mask_q;
    pending_d  = pending_q;
    if (wrap && pending_q) begin
      act_data_d = sh_data_q;
      act_dp_d   = sh_dp_q;
      act_mask_d = sh_mask_q;
      pending_d  = 1'b0;
    end

    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    sh_mask_d = sh_mask_q;
    if (wr.wr_en) begin
      sh_data_d = wr.wr_data;
      sh_dp_d   = wr.wr_dp;
      sh_mask_d = wr.wr_mask;
      pending_d = 1'b1;
    end
  end

  // Leading-zero test: every nibble at or above the current digit is zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (3'(i) >= idx_q && act_data_q[i*4 +: 4] != 4'h0) upper_zero = 1'b0;
  end

  assign nibble = act_data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_lut u_lut (
    .nib (nibble),
    .seg (seg)
  );

  always_comb begin
    blank        = !act_mask_q[idx_q] || (lzb && idx_q != 3'd0 && upper_zero);
    an_d         = blank ? AN_OFF : ~(8'd1 << idx_q);
    hex_d        = blank ? SEG_BLANK : seg;
    dp_d         = blank ? 1'b1 : ~act_dp_q[idx_q];
    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_mask_q    <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_mask_q   <= '0;
      an_q         <= AN_OFF;
      hex_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_mask_q    <= sh_mask_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_mask_q   <= act_mask_d;
      an_q         <= an_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign AN         = an_q;
  assign HEX        = hex_q;
  assign DP         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random writes, checked
// each cycle against a frame-arithmetic reference model.
module tb_seg7_scan_driver;

  localparam int CD = 4;
  localparam int ND = 8;
  localparam int FR = CD * ND;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lzb = 1'b0;
  logic [7:0] AN;
  logic [6:0] HEX;
  logic       DP;
  logic       frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver_if wr ();

  seg7_scan_driver #(.CLK_DIV(CD), .NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .lzb        (lzb),
    .AN         (AN),
    .HEX        (HEX),
    .DP         (DP),
    .frame_done (frame_done)
  );

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: n = cycles since reset release; digit = (n/CD)%ND.
  int          n;
  logic [31:0] m_sh_d, m_act_d;
  logic [7:0]  m_sh_dp, m_act_dp, m_sh_mk, m_act_mk;
  bit          m_pend;
  int          compared = 0;
  int          mismatched = 0;
  int          fd_cnt;
  logic [7:0]  lit_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    logic [7:0] e_an;
    logic [6:0] e_hex;
    logic       e_dp, e_fd;
    int         i;
    bit         blank;
    if (rst) begin
      e_an = 8'hFF; e_hex = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      n = 0; m_pend = 0;
      m_sh_d = '0; m_act_d = '0; m_sh_dp = '0; m_act_dp = '0; m_sh_mk = '0; m_act_mk = '0;
    end else begin
      i     = (n / CD) % ND;
      blank = !m_act_mk[i] || (lzb && i > 0 && (m_act_d >> (4 * i)) == 32'd0);
      e_an  = blank ? 8'hFF : ~(8'd1 << i);
      e_hex = blank ? 7'h7F : glyph[(m_act_d >> (4 * i)) & 32'hF];
      e_dp  = blank ? 1'b1 : ~m_act_dp[i];
      e_fd  = (n % FR) == FR - 1;
      if (e_fd && m_pend) begin
        m_act_d = m_sh_d; m_act_dp = m_sh_dp; m_act_mk = m_sh_mk; m_pend = 0;
      end
      if (wr.wr_en) begin
        m_sh_d = wr.wr_data; m_sh_dp = wr.wr_dp; m_sh_mk = wr.wr_mask; m_pend = 1;
      end
      n++;
    end
    @(posedge clk);
    #1;
    wr.wr_en = 1'b0;
    rst      = 1'b0;
    chk("AN", 32'(AN), 32'(e_an));
    chk("HEX", 32'(HEX), 32'(e_hex));
    chk("DP", 32'(DP), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (frame_done) fd_cnt++;
    lit_seen |= ~AN;
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] mk);
    wr.wr_en   = 1'b1;
    wr.wr_data = d;
    wr.wr_dp   = dp;
    wr.wr_mask = mk;
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  // Leaves the bench in the cycle whose closing edge is the frame wrap.
  task automatic to_wrap();
    int guard = 0;
    while ((n % FR) != FR - 1 && guard < 2 * FR) begin
      step();
      guard++;
    end
  endtask

  // Write now, run to the wrap that applies it, then watch one fresh frame.
  task automatic show_frame(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] mk);
    write(d, dp, mk);
    step();
    to_wrap();
    step();
    lit_seen = '0;
    run(FR);
  endtask

  initial begin
    n = 0;
    wr.wr_en = 1'b0; wr.wr_data = '0; wr.wr_dp = '0; wr.wr_mask = '0;

    // Reset and idle: fully blank, frame_done every FR cycles.
    rst = 1'b1; step();
    rst = 1'b1; step();
    fd_cnt = 0; lit_seen = '0;
    run(2 * FR);
    chk("idle_frame_pulses", 32'(fd_cnt), 32'd2);
    chk("idle_nothing_lit", 32'(lit_seen), 32'h0);

    // Full value, dp on digit 0.
    show_frame(32'h89AB_CDEF, 8'h01, 8'hFF);
    chk("all_digits_lit", 32'(lit_seen), 32'hFF);

    // Leading-zero blanking.
    lzb = 1'b1;
    show_frame(32'h0000_0012, 8'h00, 8'hFF);
    chk("lzb_12_lit", 32'(lit_seen), 32'h03);
    show_frame(32'h0000_0000, 8'h00, 8'hFF);
    chk("lzb_0_lit", 32'(lit_seen), 32'h01);
    lzb = 1'b0;

    // Write landing exactly on the wrap, then back-to-back writes.
    show_frame(32'h1111_1111, 8'h00, 8'hFF);
    to_wrap();
    write(32'hAAAA_AAAA, 8'hF0, 8'hFF);
    run(FR + 2);
    to_wrap();
    run(FR);
    write(32'h1234_5678, 8'h00, 8'hFF);
    step();
    write(32'hFEDC_BA98, 8'h55, 8'hFF);
    run(2 * FR);

    // Sparse enable mask.
    show_frame($urandom, 8'($urandom), 8'hA5);
    chk("mask_a5_lit", 32'(lit_seen), 32'hA5);

    // Random writes, lzb toggles, arbitrary timing.
    for (int k = 0; k < 24; k++) begin
      lzb = 1'($urandom_range(0, 1));
      write($urandom & {8{($urandom_range(0, 1) == 1) ? 4'hF : 4'h0}} | 32'($urandom_range(0, 255)),
            8'($urandom), 8'($urandom));
      run($urandom_range(1, 40));
    end

    // Mid-frame reset with a write pending: never displayed afterwards.
    to_wrap();
    run(5);
    write(32'h7777_7777, 8'hFF, 8'hFF);
    run(3);
    rst = 1'b1;
    step();
    lit_seen = '0;
    run(2 * FR);
    chk("reset_drops_pending", 32'(lit_seen), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an 8-digit common-anode seven-segment display. It holds a 32-bit hex value, decimal-point mask and digit-enable mask in double-buffered registers, and scans one digit per prescaler period. It drives the anode, segment and decimal-point pins directly. It is the output end of the value-to-display path: switch/compute logic writes a value, and this block owns the pins.

## Interface
- `CLK_DIV`, default 100000. Clocks per digit slot; must be ≥ 2. At 100 MHz this gives a 1 kHz digit rate and a 125 Hz frame rate.
- `NUM_DIGITS`, default 8. Digits scanned; fixed at 8 for this board; range 2–8.
- Clock: one clock. Reset: synchronous, active-high.
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: one-cycle write strobe into the shadow registers.
- `wr_data` input 32: nibble i is the hex value of digit i; digit 0 is rightmost.
- `wr_dp` input 8: bit i set means the decimal point of digit i is lit.
- `wr_mask` input 8: bit i set means digit i is enabled.
- `lzb` input 1: leading-zero blanking enable; sampled live, not buffered.
- `AN` output 8: anodes, active-low, one-hot-low while scanning.
- `HEX` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `DP` output 1: decimal point, active-low.
- `frame_done` output 1: one-cycle pulse when digit index wraps to 0.

## Operation
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and wraps. `tick` is asserted when `div_cnt == CLK_DIV-1`.
- On `tick`, digit index `idx` advances to idx+1, or to 0 if idx == NUM_DIGITS-1.
- Shadow registers (`sh_data`, `sh_dp`, `sh_mask`) load on `wr_en`, and `pending` is set.
- Active registers (`act_*`) are updated only on the wrap (tick with idx == NUM_DIGITS-1). If `pending` is set there, act_* <= sh_* and `pending` is cleared. This gives tear-free frame updates.
- Write coinciding with wrap:
  - act_* takes the shadow contents from before the write.
  - The new write lands in shadow and `pending` stays set, so it is applied at the next wrap.
- A digit is blanked (AN bit high, HEX = 7'h7F, DP high) when either:
  - its `act_mask` bit is 0, or
  - `lzb` = 1, idx > 0, and every nibble from idx up to NUM_DIGITS-1 is zero.
- With `lzb` = 1, digit 0 is never blanked by `lzb`; a value of 0 displays "0".
- Non-blanked digit: AN = ~(1 << idx), HEX = hex-to-segment of nibble idx (0–F, standard glyphs, b and d lower-case), DP = ~act_dp[idx].
- Unused AN bits above NUM_DIGITS-1 are held high.

## Timing
- Reset values:
  - div_cnt=0, idx=0, pending=0.
  - sh_* and act_* all 0.
  - AN=8'hFF, HEX=7'h7F, DP=1, frame_done=0.
- Outputs are registered. AN/HEX/DP reflect the idx/act_* state of the previous cycle, a 1-cycle latency.
- First lit output: the cycle after reset deasserts, digit 0 is shown if enabled. It is blank after reset because mask=0.
- Write-to-display latency: at most one full frame (NUM_DIGITS·CLK_DIV cycles) plus 1 cycle.
- `frame_done` is registered and high for exactly the one cycle in which idx = 0 first appears after a wrap.
- Reset asserted mid-frame: all state returns to reset values on that edge, including discarding any pending write. Scan restarts from digit 0 with div_cnt=0.
- `lzb` changes take effect on the next output register update; no frame alignment.

## Structure
- Package `seg7_pkg`:
  - segment glyph constants for 0–F,
  - the blank pattern 7'h7F,
  - the all-off anode constant.
- Sub-module `seg7_hex_lut`: 4-bit nibble to 7-bit active-low segments, purely combinational. It is instantiated once, fed by the muxed nibble.
- The top level contains the prescaler, index counter, shadow/active registers, blanking logic and output registers.

## Test plan
All scenarios run with CLK_DIV=4 and NUM_DIGITS=8.
- Reset, then idle 40 cycles → AN=8'hFF, HEX=7'h7F, DP=1 throughout; frame_done pulses every 32 cycles.
- Write data=32'h89AB_CDEF, mask=8'hFF, dp=8'h01 → after the next wrap, digit 0 shows AN=8'hFE, HEX=glyph F, DP=0; each digit is held 4 cycles; digit 7 shows glyph 8 with DP=1.
- Write 32'h0000_0012, mask=8'hFF, lzb=1 → only digits 0 and 1 light ("2","1"); digits 2–7 AN bits stay high. Same test with value 0 → only digit 0 lit, showing "0".
- Write coinciding with wrap:
  - Write A in the wrap cycle → the display keeps the previous shadow value for this frame.
  - A appears after the following wrap.
  - Back-to-back writes A then B within one frame → only B is displayed.
- Mask 8'b1010_0101 → only digits 0, 2, 5 and 7 ever drive an AN bit low.
- Assert rst for 1 cycle mid-frame with a write pending → all outputs return to reset values next cycle; the pending write is never displayed.
